// File: rtl/anubis_decrypt.sv
// rtl/anubis_decrypt.sv - Anubis-128 iterative decryption core with a stored round-key file
// Optional ANUBIS_DEC_PRETHETA_EN: store Theta(K^r) for r=1..11 so the round path needs a single Theta.
module anubis_decrypt #(
    parameter int ROUNDS = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_load,
    input  logic [127:0] data_in,
    input  logic         start,
    output logic         key_ready,
    output logic         busy,
    output logic [127:0] data_out,
    output logic         out_valid
);

    localparam logic [3:0]  LAST  = 4'(ROUNDS);
    localparam logic [63:0] P_TAB = 64'h3FE054BCDA967821;
    localparam logic [63:0] Q_TAB = 64'h9E56A23CF04D7B18;

    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} fsm_t;

    function automatic logic [3:0] mini_p(input logic [3:0] x);
        return P_TAB[63 - 4 * int'(x) -: 4];
    endfunction

    function automatic logic [3:0] mini_q(input logic [3:0] x);
        return Q_TAB[63 - 4 * int'(x) -: 4];
    endfunction

    // Involutional S-box: (P,Q) / swap / (Q,P) / swap / (P,Q).
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [3:0] u, l, uu, ll;
        u  = mini_p(x[7:4]);
        l  = mini_q(x[3:0]);
        uu = {u[3:2], l[3:2]};
        ll = {u[1:0], l[1:0]};
        u  = mini_q(uu);
        l  = mini_p(ll);
        uu = {u[3:2], l[3:2]};
        ll = {u[1:0], l[1:0]};
        return {mini_p(uu), mini_q(ll)};
    endfunction

    // Byte b = 4*row + col, byte 0 in the most significant position.
    function automatic logic [7:0] byte_at(input logic [127:0] v, input int idx);
        return v[127 - 8 * idx -: 8];
    endfunction

    function automatic logic [127:0] gamma(input logic [127:0] a);
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) begin
            r[127 - 8 * b -: 8] = sbox(byte_at(a, b));
        end
        return r;
    endfunction

    function automatic logic [127:0] tau(input logic [127:0] a);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                r[127 - 8 * (4 * i + j) -: 8] = byte_at(a, 4 * j + i);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] pi(input logic [127:0] a);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                r[127 - 8 * (4 * i + j) -: 8] = byte_at(a, 4 * ((i - j) & 3) + j);
            end
        end
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
    endfunction

    // Multiply by the Hadamard coefficient h[sel] from {01,02,04,06}.
    function automatic logic [7:0] hmul(input logic [7:0] a, input logic [1:0] sel);
        logic [7:0] a2, a4;
        a2 = xtime(a);
        a4 = xtime(a2);
        case (sel)
            2'd0:    return a;
            2'd1:    return a2;
            2'd2:    return a4;
            default: return a4 ^ a2;
        endcase
    endfunction

    function automatic logic [127:0] theta(input logic [127:0] a);
        logic [127:0] r;
        logic [7:0]   acc;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ hmul(byte_at(a, 4 * i + k), 2'(k ^ j));
                end
                r[127 - 8 * (4 * i + j) -: 8] = acc;
            end
        end
        return r;
    endfunction

    // K^r = sigma[c^r](Theta(Pi(Gamma(K^(r-1))))), c^r row 0 = S[4(r-1)+j].
    function automatic logic [127:0] key_sched(input logic [127:0] k, input logic [3:0] r);
        logic [127:0] t;
        logic [3:0]   rm1;
        t   = theta(pi(gamma(k)));
        rm1 = r - 4'd1;
        for (int j = 0; j < 4; j++) begin
            t[127 - 8 * j -: 8] = byte_at(t, j) ^ sbox({2'b00, rm1, 2'(j)});
        end
        return t;
    endfunction

    fsm_t         fsm_q;
    logic [3:0]   cnt_q;
    logic [127:0] rk_q [0:ROUNDS];
    logic [127:0] st_q;
    logic         key_ready_q;
    logic         busy_q;
    logic [127:0] data_out_q;
    logic         out_valid_q;
`ifdef ANUBIS_DEC_PRETHETA_EN
    logic [127:0] shadow_q;
`endif

    logic [127:0] ks_next;
    logic [127:0] rk_store;
    logic [127:0] dk_round;
    logic [127:0] gt;
    logic [127:0] round_out;
    logic [127:0] final_out;

    always_comb begin
`ifdef ANUBIS_DEC_PRETHETA_EN
        // The chain runs on raw keys; only the stored copy is pre-mixed.
        ks_next  = key_sched(shadow_q, cnt_q);
        rk_store = (cnt_q == LAST) ? ks_next : theta(ks_next);
        dk_round = rk_q[LAST - cnt_q];
`else
        ks_next  = key_sched(rk_q[cnt_q - 4'd1], cnt_q);
        rk_store = ks_next;
        dk_round = theta(rk_q[LAST - cnt_q]);
`endif
        gt        = tau(gamma(st_q));
        round_out = theta(gt) ^ dk_round;
        final_out = gt ^ rk_q[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q       <= IDLE;
            cnt_q       <= 4'd0;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (key_load && (fsm_q == IDLE || fsm_q == EXPAND)) begin
            // A fresh key wins over a same-cycle start and restarts a running expansion.
            rk_q[0]     <= key_in;
`ifdef ANUBIS_DEC_PRETHETA_EN
            shadow_q    <= key_in;
`endif
            cnt_q       <= 4'd1;
            key_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            fsm_q       <= EXPAND;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (start && key_ready_q) begin
                        st_q   <= data_in ^ rk_q[LAST];
                        cnt_q  <= 4'd1;
                        busy_q <= 1'b1;
                        fsm_q  <= DECRYPT;
                    end
                end
                EXPAND: begin
                    rk_q[cnt_q] <= rk_store;
`ifdef ANUBIS_DEC_PRETHETA_EN
                    shadow_q    <= ks_next;
`endif
                    if (cnt_q == LAST) begin
                        key_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        cnt_q       <= 4'd0;
                        fsm_q       <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DECRYPT: begin
                    if (cnt_q == LAST) begin
                        data_out_q  <= final_out;
                        out_valid_q <= 1'b1;
                        cnt_q       <= 4'd0;
                        fsm_q       <= DONE;
                    end else begin
                        st_q  <= round_out;
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    fsm_q       <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign key_ready = key_ready_q;
    assign busy      = busy_q;
    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_anubis_decrypt.sv
// tb/tb_anubis_decrypt.sv - randomized round-trip bench: software Anubis encryption feeds the decryption core
module tb_anubis_decrypt;

    typedef logic [0:3][0:3][7:0] mat_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key_in;
    logic         key_load;
    logic [127:0] data_in;
    logic         start;
    logic         key_ready;
    logic         busy;
    logic [127:0] data_out;
    logic         out_valid;

    always #5 clk = ~clk;

    anubis_decrypt dut (
        .clk       (clk),
        .reset     (reset),
        .key_in    (key_in),
        .key_load  (key_load),
        .data_in   (data_in),
        .start     (start),
        .key_ready (key_ready),
        .busy      (busy),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ov_count = 0;
    int busy_count = 0;

    always @(negedge clk) begin
        if (out_valid) ov_count++;
        if (busy) busy_count++;
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned mini [2][16] = '{'{3, 15, 14, 0, 5, 4, 11, 12, 13, 10, 9, 6, 7, 8, 2, 1},
                                  '{9, 14, 5, 6, 10, 2, 3, 12, 15, 0, 4, 13, 7, 11, 1, 8}};
    int unsigned hv [4] = '{1, 2, 4, 6};
    logic [7:0]  sb [256];

    function automatic int gmul(input int a, input int b);
        int r = 0;
        for (int i = 0; i < 8; i++) begin
            if ((b >> i) & 1) r = r ^ a;
            a = a << 1;
            if (a & 'h100) a = a ^ 'h11d;
        end
        return r;
    endfunction

    function automatic mat_t m_gamma(input mat_t a);
        mat_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) r[i][j] = sb[a[i][j]];
        return r;
    endfunction

    function automatic mat_t m_tau(input mat_t a);
        mat_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) r[i][j] = a[j][i];
        return r;
    endfunction

    function automatic mat_t m_pi(input mat_t a);
        mat_t r;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) r[i][j] = a[(i - j + 4) % 4][j];
        return r;
    endfunction

    function automatic mat_t m_theta(input mat_t a);
        mat_t r;
        int   acc;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(int'(a[i][k]), int'(hv[k ^ j]));
                r[i][j] = 8'(acc);
            end
        return r;
    endfunction

    function automatic mat_t m_ks(input mat_t k, input int r);
        mat_t t;
        t = m_theta(m_pi(m_gamma(k)));
        for (int j = 0; j < 4; j++) t[0][j] = t[0][j] ^ sb[4 * (r - 1) + j];
        return t;
    endfunction

    // Forward Anubis-128 encryption, as the companion encryption core computes it.
    function automatic logic [127:0] enc(input logic [127:0] key, input logic [127:0] pt);
        mat_t k [13];
        mat_t s;
        k[0] = key;
        for (int r = 1; r <= 12; r++) k[r] = m_ks(k[r - 1], r);
        s = mat_t'(pt) ^ k[0];
        for (int r = 1; r <= 11; r++) s = m_theta(m_tau(m_gamma(s))) ^ k[r];
        s = m_tau(m_gamma(s)) ^ k[12];
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus tasks ----------------
    task automatic load_key(input logic [127:0] k, input logic with_start, input logic [127:0] d);
        int n;
        int ov0;
        ov0 = ov_count;
        @(negedge clk);
        key_in   = k;
        key_load = 1'b1;
        start    = with_start;
        data_in  = d;
        @(negedge clk);
        key_load = 1'b0;
        start    = 1'b0;
        check_eq("expand_busy", busy, 1);
        check_eq("expand_key_ready_low", key_ready, 0);
        n = 0;
        while (!key_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("expand_cycles", n, 12);
        check_eq("expand_busy_end", busy, 0);
        if (with_start) check_eq("dropped_start_pulses", ov_count - ov0, 0);
    endtask

    task automatic run_decrypt(input logic [127:0] ct, input logic [127:0] exp_pt, input logic noisy,
                               input string tag);
        int n;
        int ov0;
        @(negedge clk);
        data_in = ct;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ov0   = ov_count;
        check_eq({tag, "_busy"}, busy, 1);
        n = 0;
        while (!out_valid && n < 40) begin
            if (noisy && n < 9) begin
                start    = 1'b1;
                key_load = 1'b1;
                data_in  = rand128();
                key_in   = rand128();
            end else begin
                start    = 1'b0;
                key_load = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start    = 1'b0;
        key_load = 1'b0;
        check_eq({tag, "_latency"}, n, 12);
        check_eq({tag, "_data"}, data_out, exp_pt);
        @(negedge clk);
        check_eq({tag, "_valid_fall"}, out_valid, 0);
        check_eq({tag, "_busy_fall"}, busy, 0);
        check_eq({tag, "_data_hold"}, data_out, exp_pt);
        check_eq({tag, "_pulses"}, ov_count - ov0, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] k;
        logic [127:0] pt;
        int           ov0;
        int           b0;

        reset    = 1'b1;
        key_load = 1'b0;
        start    = 1'b0;
        key_in   = '0;
        data_in  = '0;

        for (int x = 0; x < 256; x++) begin
            int hi, lo, t;
            hi = x >> 4;
            lo = x & 15;
            for (int layer = 0; layer < 3; layer++) begin
                hi = int'(mini[(layer == 1) ? 1 : 0][hi]);
                lo = int'(mini[(layer == 1) ? 0 : 1][lo]);
                if (layer < 2) begin
                    t  = (hi & 'hC) | (lo >> 2);
                    lo = ((hi & 3) << 2) | (lo & 3);
                    hi = t;
                end
            end
            sb[x] = 8'(hi * 16 + lo);
        end

        repeat (3) @(negedge clk);
        check_eq("rst_key_ready", key_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_data_out", data_out, 0);
        check_eq("rst_out_valid", out_valid, 0);
        reset = 1'b0;

        // start without a key is ignored
        ov0 = ov_count;
        b0  = busy_count;
        @(negedge clk);
        start   = 1'b1;
        data_in = rand128();
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check_eq("nokey_busy", busy_count - b0, 0);
        check_eq("nokey_valid", ov_count - ov0, 0);
        check_eq("nokey_data", data_out, 0);

        // all-zero key and plaintext
        load_key('0, 1'b0, '0);
        run_decrypt(enc('0, '0), '0, 1'b0, "zero");

        // known plaintext under key 0x8000..0
        k  = {1'b1, 127'b0};
        pt = 128'h0123456789ABCDEF_FEDCBA9876543210;
        load_key(k, 1'b0, '0);
        run_decrypt(enc(k, pt), pt, 1'b0, "known");

        // key_load with simultaneous start: block dropped; then noisy strobes during DECRYPT
        k  = rand128();
        pt = rand128();
        load_key(k, 1'b1, enc(k, pt));
        repeat (3) @(negedge clk);
        check_eq("collide_idle_busy", busy, 0);
        run_decrypt(enc(k, pt), pt, 1'b1, "noisy");

        // reset during round 6
        @(negedge clk);
        data_in = enc(k, rand128());
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_key_ready", key_ready, 0);
        check_eq("midrst_data_out", data_out, 0);
        check_eq("midrst_out_valid", out_valid, 0);
        k  = rand128();
        pt = rand128();
        load_key(k, 1'b0, '0);
        run_decrypt(enc(k, pt), pt, 1'b0, "reload");

        // random round trips
        for (int t = 0; t < 100; t++) begin
            k  = rand128();
            pt = rand128();
            load_key(k, 1'b0, '0);
            run_decrypt(enc(k, pt), pt, 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/anubis_decrypt.md
Name: anubis_decrypt

Overview:
Anubis-128 decryption core (N=4, R=12 rounds), the inverse-direction partner of the team's iterative Anubis encryption core.
- Expands the master key once, storing all 13 round keys K^0..K^12.
- Decrypts one 128-bit block per request by walking the stored keys in reverse order.
- Sits beside the encryption core on the same 128-bit datapath.
- Reuses the existing Gamma, Tau, Theta and Key_Schedule blocks.

Parameters:
ROUNDS, 12, number of Anubis rounds R. Fixed for 128-bit keys; other values unsupported.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
key_in  in  128  master key K^0
key_load  in  1  one-cycle strobe; captures key_in and starts key expansion
data_in  in  128  ciphertext block
start  in  1  one-cycle strobe; captures data_in and starts decryption
key_ready  out  1  round-key store is valid
busy  out  1  expansion or decryption in progress
data_out  out  128  plaintext; holds until the next result or reset
out_valid  out  1  one-cycle pulse when data_out is updated

Behaviour:
- Reset values: key_ready=0, busy=0, data_out=0, out_valid=0, FSM in IDLE, round counter=0.
- FSM states: IDLE, EXPAND, DECRYPT, DONE.
- IDLE, key_load=1:
  - rk[0]<=key_in, cnt<=1, key_ready<=0, goto EXPAND.
  - key_load has priority over a simultaneous start; that start is dropped.
- EXPAND:
  - Each cycle: rk[cnt]<=Key_Schedule(rk[cnt-1], cnt); cnt++.
  - After the edge that writes rk[12]: key_ready<=1, goto IDLE.
  - Takes 12 cycles; busy=1 throughout.
  - key_load during EXPAND restarts expansion with the new key.
- IDLE, start=1, key_ready=1:
  - state<=data_in ^ rk[12] (dk[0]=K^12), cnt<=1, goto DECRYPT.
  - start with key_ready=0 is ignored.
- DECRYPT, cnt=1..11:
  - state<=Theta(Tau(Gamma(state))) ^ Theta(rk[12-cnt]); cnt++.
  - Decryption key dk[r]=Theta(K^(12-r)).
- DECRYPT, cnt=12:
  - data_out<=Tau(Gamma(state)) ^ rk[0]; out_valid<=1; goto DONE.
- DONE: out_valid<=0, busy<=0, goto IDLE.
- Latency: start sampled at edge T; out_valid high in the cycle after edge T+12. Throughput is one block per 14 cycles.
- busy is high from the edge after an accepted start/key_load until the DONE→IDLE edge.
- During DECRYPT, start and key_load are ignored; the round keys are never modified mid-block.
- A new start is accepted in the first IDLE cycle after DONE.
- data_out is registered and not cleared by out_valid falling.
- Reset mid-operation: everything returns to reset values and key_ready=0, so the key must be reloaded.
- Round counter is 4 bits; no wrap occurs because the maximum value is 12.

Optional Feature:
Macro ANUBIS_DEC_PRETHETA_EN.
- Defined:
  - During EXPAND, rk[1..11] store Theta(K^r) instead of K^r; the DECRYPT datapath uses rk directly.
  - Removes the second Theta instance from the round path.
  - EXPAND is still 12 cycles. Each Key_Schedule step feeds from an unmodified shadow copy of the previous K, since the chain must use K, not Theta(K).
- Undefined: raw keys are stored and Theta is applied on the fly during DECRYPT.
- External timing and data_out are identical in both builds.

Test Plan:
- Key 0x000…0, then ciphertext = golden-model encryption of 0x000…0 -> key_ready after 12 cycles; data_out=0x000…0 with out_valid 12 cycles after start.
- Key 0x8000…0, plaintext 0x0123456789ABCDEF_FEDCBA9876543210 encrypted by the team's encryption core -> decrypt returns exactly that plaintext; out_valid high for exactly 1 cycle.
- start asserted with key_ready=0 after reset -> no busy, no out_valid, data_out stays 0.
- start and key_load in the same IDLE cycle -> expansion runs, block dropped; start pulses during DECRYPT -> ignored, single result.
- Reset asserted at round 6 of DECRYPT -> next cycle busy=0, key_ready=0, data_out=0; a reload plus decrypt then succeeds.
- 100 random key/plaintext pairs round-tripped through the encryption core, run in both macro builds -> all plaintexts match, cycle counts identical.
